// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: merges NUM_SRC valid/ready streams into one output stream.
// The grant is held for a whole packet or MAX_BURST beats, whichever ends first.
// The datapath is pure combinational muxing with no storage; only the
// arbitration state is registered.
module stream_rr_arbiter #(
   parameter int WIDTH     = 64,
   parameter int NUM_SRC   = 4,
   parameter int LOG_SRC   = 2,
   parameter int MAX_BURST = 16,
   parameter int LOG_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SRC*WIDTH-1:0]   ss_data,
   input  logic [NUM_SRC-1:0]         ss_valid,
   input  logic [NUM_SRC-1:0]         ss_last,
   output logic [NUM_SRC-1:0]         ss_ready,
   output logic [WIDTH-1:0]           ms_data,
   output logic [LOG_SRC-1:0]         ms_src,
   output logic                       ms_last,
   output logic                       ms_valid,
   input  logic                       ms_ready
);

   localparam logic [0:0]         IDLE      = 1'b0;
   localparam logic [0:0]         GRANT     = 1'b1;
   localparam logic [LOG_SRC:0]   NSRC      = (LOG_SRC+1)'(NUM_SRC);
   localparam logic [LOG_SRC-1:0] LAST_SRC  = LOG_SRC'(NUM_SRC-1);
   localparam logic [LOG_BURST:0] BURST_END = (LOG_BURST+1)'(MAX_BURST-1);

   logic [0:0]         r_fsm;
   logic [LOG_SRC-1:0] r_grant;
   logic [LOG_SRC-1:0] r_prio;
   logic [LOG_BURST:0] r_beat_cnt;

   logic               w_found;
   logic [LOG_SRC-1:0] w_pick;
   logic [LOG_SRC:0]   w_idx;
   logic [WIDTH-1:0]   w_sel_data;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic               w_granted;
   logic               w_accept;
   logic               w_release;

   // Round-robin search: walk downwards so the candidate closest to prio wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = NUM_SRC-1; k >= 0; k--) begin
         w_idx = {1'b0, r_prio} + (LOG_SRC+1)'(k);
         if (w_idx >= NSRC) w_idx = w_idx - NSRC;
         if (ss_valid[w_idx[LOG_SRC-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[LOG_SRC-1:0];
         end
      end
   end

   // Select the granted source's data, valid and last.
   always_comb begin
      w_sel_data  = '0;
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_grant == LOG_SRC'(i)) begin
            w_sel_data  = ss_data[i*WIDTH +: WIDTH];
            w_sel_valid = ss_valid[i];
            w_sel_last  = ss_last[i];
         end
      end
   end

   // Output stream and per-source ready; reset masks handshakes immediately.
   always_comb begin
      w_granted = (r_fsm == GRANT) && !reset;
      ms_valid  = w_granted && w_sel_valid;
      ms_data   = (r_fsm == GRANT) ? w_sel_data : '0;
      ms_last   = (r_fsm == GRANT) ? w_sel_last : 1'b0;
      ms_src    = r_grant;
      for (int i = 0; i < NUM_SRC; i++) begin
         ss_ready[i] = w_granted && ms_ready && (r_grant == LOG_SRC'(i));
      end
      w_accept  = ms_valid && ms_ready;
      // A burst-limit release leaves ms_last untouched; the packet resumes later.
      w_release = w_accept && (w_sel_last || (r_beat_cnt == BURST_END));
   end

   // Arbitration state: pick a source in IDLE, count beats and release in GRANT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm      <= IDLE;
         r_grant    <= '0;
         r_prio     <= '0;
         r_beat_cnt <= '0;
      end else if (r_fsm == IDLE) begin
         if (w_found) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
            r_fsm      <= GRANT;
         end
      end else begin
         if (w_release) begin
            r_fsm  <= IDLE;
            r_prio <= (r_grant == LAST_SRC) ? '0 : r_grant + 1'b1;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter: a 4-source/16-burst instance and a
// 3-source/4-burst instance, each compared every cycle with a packet-level
// reference model, plus directed scenarios with fixed expected beat logs.
module tb_stream_rr_arbiter;

   localparam int W = 16;

   typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
   typedef struct { bit busy; int grant; int prio; int taken; } mdl_t;
   typedef struct { logic valid; logic last; int src; logic [3:0] ready; logic [W-1:0] data; } exp_t;
   typedef struct { int src; logic [W-1:0] d; logic l; int cyc; } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [4*W-1:0] d4;
   logic [3:0]     v4, l4, sr4;
   logic [W-1:0]   md4;
   logic [1:0]     ms4;
   logic           ml4, mv4, mr4;
   logic [3*W-1:0] d3;
   logic [2:0]     v3, l3, sr3;
   logic [W-1:0]   md3;
   logic [1:0]     ms3;
   logic           ml3, mv3, mr3;

   stream_rr_arbiter #(.WIDTH(W), .NUM_SRC(4), .LOG_SRC(2), .MAX_BURST(16), .LOG_BURST(4)) u_dut4 (
      .clk(clk), .reset(rst), .ss_data(d4), .ss_valid(v4), .ss_last(l4), .ss_ready(sr4),
      .ms_data(md4), .ms_src(ms4), .ms_last(ml4), .ms_valid(mv4), .ms_ready(mr4));

   stream_rr_arbiter #(.WIDTH(W), .NUM_SRC(3), .LOG_SRC(2), .MAX_BURST(4), .LOG_BURST(2)) u_dut3 (
      .clk(clk), .reset(rst), .ss_data(d3), .ss_valid(v3), .ss_last(l3), .ss_ready(sr3),
      .ms_data(md3), .ms_src(ms3), .ms_last(ml3), .ms_valid(mv3), .ms_ready(mr3));

   int    n_vec = 0;
   int    n_err = 0;
   int    cycle = 0;
   mdl_t  m4, m3;
   beat_t q4[4][$];
   beat_t q3[3][$];
   obs_t  log4[$];
   obs_t  log3[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   // Expected outputs from the model state and the current inputs.
   function automatic exp_t mdl_out(mdl_t m, bit r, logic [4*W-1:0] d, logic [3:0] v, logic [3:0] l, bit rdy);
      exp_t e;
      e.src = m.grant; e.valid = 1'b0; e.last = 1'b0; e.ready = '0; e.data = '0;
      if (m.busy) begin
         e.data = d[m.grant*W +: W];
         e.last = l[m.grant];
         if (!r) begin
            e.valid = v[m.grant];
            if (rdy) e.ready[m.grant] = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic mdl_step(inout mdl_t m, input int n, input int maxb, input bit r,
                           input logic [3:0] v, input logic [3:0] l, input bit acc);
      if (r) begin
         m.busy = 0; m.grant = 0; m.prio = 0; m.taken = 0;
      end else if (!m.busy) begin
         for (int k = 0; k < n; k++) begin
            if (!m.busy && v[(m.prio + k) % n]) begin
               m.busy = 1; m.grant = (m.prio + k) % n; m.taken = 0;
            end
         end
      end else if (acc) begin
         m.taken++;
         if (l[m.grant] || m.taken == maxb) begin
            m.busy = 0; m.prio = (m.grant + 1) % n;
         end
      end
   endtask

   task automatic push4(input int s, input int base, input int step, input int len);
      for (int j = 0; j < len; j++) q4[s].push_back({W'(base + j*step), j == len-1});
   endtask

   task automatic push3(input int s, input int base, input int step, input int len);
      for (int j = 0; j < len; j++) q3[s].push_back({W'(base + j*step), j == len-1});
   endtask

   task automatic drive();
      for (int s = 0; s < 4; s++) begin
         if (q4[s].size() != 0) begin
            v4[s] = 1'b1; d4[s*W +: W] = q4[s][0].d; l4[s] = q4[s][0].l;
         end else begin
            v4[s] = 1'b0; d4[s*W +: W] = W'($urandom); l4[s] = 1'($urandom);
         end
      end
      for (int s = 0; s < 3; s++) begin
         if (q3[s].size() != 0) begin
            v3[s] = 1'b1; d3[s*W +: W] = q3[s][0].d; l3[s] = q3[s][0].l;
         end else begin
            v3[s] = 1'b0; d3[s*W +: W] = W'($urandom); l3[s] = 1'($urandom);
         end
      end
   endtask

   // One clock cycle: drive, compare against the model, advance on the edge.
   task automatic cyc();
      exp_t e4, e3;
      bit   a4, a3;
      int   g4, g3;
      drive();
      #3;
      e4 = mdl_out(m4, rst, d4, v4, l4, mr4);
      e3 = mdl_out(m3, rst, 64'(d3), {1'b0, v3}, {1'b0, l3}, mr3);
      chk("valid4", 64'(mv4), 64'(e4.valid));
      chk("ready4", 64'(sr4), 64'(e4.ready));
      chk("src4",   64'(ms4), 64'(e4.src));
      chk("data4",  64'(md4), 64'(e4.data));
      chk("last4",  64'(ml4), 64'(e4.last));
      chk("valid3", 64'(mv3), 64'(e3.valid));
      chk("ready3", 64'(sr3), 64'(e3.ready[2:0]));
      chk("src3",   64'(ms3), 64'(e3.src));
      chk("data3",  64'(md3), 64'(e3.data));
      chk("last3",  64'(ml3), 64'(e3.last));
      if (mv4 && mr4) log4.push_back('{int'(ms4), md4, ml4, cycle});
      if (mv3 && mr3) log3.push_back('{int'(ms3), md3, ml3, cycle});
      a4 = e4.valid && mr4; g4 = m4.grant;
      a3 = e3.valid && mr3; g3 = m3.grant;
      @(posedge clk);
      if (a4) void'(q4[g4].pop_front());
      if (a3) void'(q3[g3].pop_front());
      mdl_step(m4, 4, 16, rst, v4, l4, a4);
      mdl_step(m3, 3, 4, rst, {1'b0, v3}, {1'b0, l3}, a3);
      cycle++;
      #1;
   endtask

   task automatic exp_beat(input string tag, input obs_t o, input int src, input int d, input bit l);
      chk({tag, "_src"},  64'(o.src), 64'(src));
      chk({tag, "_data"}, 64'(o.d),   64'(W'(d)));
      chk({tag, "_last"}, 64'(o.l),   64'(l));
   endtask

   initial begin
      int start;
      int acc_cyc[4];
      logic rdy_pat[8];
      rst = 1'b1; mr4 = 1'b1; mr3 = 1'b1;
      m4 = '{0, 0, 0, 0}; m3 = '{0, 0, 0, 0};
      drive();
      @(posedge clk); #1;
      cyc(); cyc();
      chk("rst_valid", 64'(mv4), 64'd0);
      chk("rst_ready", 64'(sr4), 64'd0);
      chk("rst_src",   64'(ms4), 64'd0);
      chk("rst_data",  64'(md4), 64'd0);
      rst = 1'b0;
      cyc();

      // Every source holds 1-beat packets: 0,1,2,3,0 with one idle cycle between.
      for (int s = 0; s < 4; s++) begin push4(s, 'h100*s, 0, 1); push4(s, 'h100*s + 1, 0, 1); end
      log4.delete(); start = cycle;
      repeat (20) cyc();
      chk("rr_count", 64'(log4.size()), 64'd8);
      for (int k = 0; k < 5 && k < log4.size(); k++) begin
         exp_beat("rr", log4[k], k % 4, 'h100*(k % 4) + (k / 4), 1'b1);
         chk("rr_cycle", 64'(log4[k].cyc), 64'(start + 1 + 2*k));
      end

      // Three-beat packet from source 0 after one idle cycle.
      push4(0, 'h11, 'h11, 3);
      log4.delete(); start = cycle;
      repeat (6) cyc();
      chk("pkt3_count", 64'(log4.size()), 64'd3);
      for (int k = 0; k < 3 && k < log4.size(); k++) begin
         exp_beat("pkt3", log4[k], 0, 'h11*(k+1), k == 2);
         chk("pkt3_cycle", 64'(log4[k].cyc), 64'(start + 1 + k));
      end

      // prio is now 1: source 1 wins over source 0.
      push4(0, 'h44, 0, 1); push4(1, 'h55, 0, 1);
      log4.delete();
      repeat (6) cyc();
      chk("prio1_count", 64'(log4.size()), 64'd2);
      if (log4.size() >= 2) begin
         exp_beat("prio1_a", log4[0], 1, 'h55, 1'b1);
         exp_beat("prio1_b", log4[1], 0, 'h44, 1'b1);
      end

      // 20-beat packet split by the 16-beat limit with source 3 in between.
      push4(2, 'h200, 1, 20); push4(3, 'h300, 1, 2);
      log4.delete();
      repeat (30) cyc();
      chk("burst_count", 64'(log4.size()), 64'd22);
      for (int k = 0; k < 22 && k < log4.size(); k++) begin
         if (k < 16)      exp_beat("burst_a", log4[k], 2, 'h200 + k, 1'b0);
         else if (k < 18) exp_beat("burst_b", log4[k], 3, 'h300 + k - 16, k == 17);
         else             exp_beat("burst_c", log4[k], 2, 'h200 + k - 2, k == 21);
      end

      // ms_ready stalls during a 4-beat packet from source 1.
      rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      acc_cyc = '{1, 4, 5, 6};
      push4(1, 'h500, 1, 4);
      log4.delete(); start = cycle;
      for (int k = 0; k < 8; k++) begin mr4 = rdy_pat[k]; cyc(); end
      mr4 = 1'b1;
      chk("stall_count", 64'(log4.size()), 64'd4);
      for (int k = 0; k < 4 && k < log4.size(); k++) begin
         exp_beat("stall", log4[k], 1, 'h500 + k, k == 3);
         chk("stall_cycle", 64'(log4[k].cyc), 64'(start + acc_cyc[k]));
      end

      // Reset after two beats of source 1; prio returns to 0.
      push4(1, 'h600, 1, 4);
      repeat (3) cyc();
      rst = 1'b1; push4(3, 'h700, 0, 1);
      cyc();
      chk("midrst_valid", 64'(mv4), 64'd0);
      chk("midrst_ready", 64'(sr4), 64'd0);
      rst = 1'b0;
      log4.delete(); start = cycle;
      repeat (8) cyc();
      chk("midrst_count", 64'(log4.size()), 64'd3);
      if (log4.size() >= 3) begin
         exp_beat("midrst_a", log4[0], 1, 'h602, 1'b0);
         exp_beat("midrst_b", log4[1], 1, 'h603, 1'b1);
         exp_beat("midrst_c", log4[2], 3, 'h700, 1'b1);
         chk("midrst_cycle", 64'(log4[0].cyc), 64'(start + 1));
      end

      // Three sources: source 2 releases, prio wraps to 0.
      push3(1, 'h31, 0, 1);
      repeat (4) cyc();
      push3(2, 'h32, 0, 1); push3(2, 'h34, 0, 1); push3(0, 'h30, 0, 1);
      log3.delete();
      repeat (10) cyc();
      chk("wrap_count", 64'(log3.size()), 64'd3);
      if (log3.size() >= 3) begin
         exp_beat("wrap_a", log3[0], 2, 'h32, 1'b1);
         exp_beat("wrap_b", log3[1], 0, 'h30, 1'b1);
         exp_beat("wrap_c", log3[2], 2, 'h34, 1'b1);
      end

      // Randomized traffic, backpressure and occasional resets.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         mr4 = ($urandom_range(0, 3) != 0);
         mr3 = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < 4; s++)
            if (q4[s].size() == 0 && $urandom_range(0, 3) == 0)
               push4(s, int'($urandom_range(0, 65535)), 1, int'($urandom_range(1, 20)));
         for (int s = 0; s < 3; s++)
            if (q3[s].size() == 0 && $urandom_range(0, 3) == 0)
               push3(s, int'($urandom_range(0, 65535)), 1, int'($urandom_range(1, 8)));
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
